riscv_dbg_target: RTL and testbench
===================================

# riscv_dbg_target

Per-core debug target that terminates the debug bus driven by the debug controller model: it decodes `stb/we/adr/dat` requests into internal control, status and breakpoint registers, or forwards them to the core's register-file debug port. It also watches the retiring instruction stream and raises a breakpoint request back to the controller on hardware-breakpoint, ebreak or single-step hits. One instance sits inside each core, directly downstream of the controller's per-core `cpu_*` signal set.

## Interface
- `XLEN`, 64, data and PC width
- `PLEN`, 64, debug address width
- `BREAKPOINTS`, 4, number of hardware breakpoints (1..8)

- `clk`  in  1  clock
- `rst`  in  1  reset; asynchronous, active-high
- `dbg_stall_i`  in  1  core stalled by debug controller
- `dbg_stb_i`  in  1  request strobe; held until ack
- `dbg_we_i`  in  1  1 = write, 0 = read
- `dbg_adr_i`  in  PLEN  request address
- `dbg_dat_i`  in  XLEN  write data
- `dbg_dat_o`  out  XLEN  read data, valid with `dbg_ack_o`
- `dbg_ack_o`  out  1  one-cycle acknowledge
- `dbg_bp_o`  out  1  breakpoint request, level; equals OR of HIT
- `pipe_valid_i`  in  1  instruction retiring this cycle
- `pipe_pc_i`  in  XLEN  PC of retiring instruction
- `pipe_ebreak_i`  in  1  retiring instruction is ebreak
- `gpr_req_o`  out  1  register-file access request
- `gpr_we_o`  out  1  register-file write
- `gpr_idx_o`  out  5  register index
- `gpr_dat_o`  out  XLEN  register write data
- `gpr_dat_i`  in  XLEN  register read data, valid with `gpr_ack_i`
- `gpr_ack_i`  in  1  register-file acknowledge
- `npc_o`  out  XLEN  resume PC
- `npc_we_o`  out  1  one-cycle pulse: load `npc_o` into the core PC

## Operation
- Region is `dbg_adr_i[13:12]`: 0 = internal, 1 = GPR, 2/3 = unmapped. Offset is `dbg_adr_i[7:3]`; `adr[2:0]` are ignored.
- Internal registers, by byte offset:
  - 0x00 CTRL: bit0 single_step, bit1 ebreak_en. R/W.
  - 0x08 HIT: bit0 step, bit1 ebreak, bit(2+n) bp n. Read returns status; write-1-to-clear.
  - 0x10 NPC: read returns the captured hit PC. A write loads it, drives `npc_o` and pulses `npc_we_o`.
  - 0x80+16n BPADR n: R/W, XLEN bits.
  - 0x88+16n BPCTRL n: bit0 enable. R/W.
  - Registers with n ≥ BREAKPOINTS, and unmapped offsets, read 0; writes to them are dropped. Unused register bits read 0.
- GPR region: `gpr_idx_o = adr[7:3]`.
  - The access is performed only while `dbg_stall_i` = 1.
  - Otherwise the request is acked with read data 0 and the write is dropped.
- FSM states:
  - IDLE: on `dbg_stb_i`, go to GPR for a stalled GPR access; otherwise perform the access, set `dbg_ack_o`, and go to RELEASE.
  - GPR: `gpr_req_o` = 1, with `gpr_we_o`/`gpr_idx_o`/`gpr_dat_o` stable. On the edge that samples `gpr_ack_i`: clear `gpr_req_o`, set `dbg_ack_o`, set `dbg_dat_o` = `gpr_dat_i` on reads, go to RELEASE.
  - RELEASE: `dbg_ack_o` is cleared. Stay until `dbg_stb_i` = 0, then go to IDLE. A held strobe is never served twice.
- Hit detection runs every cycle in which `pipe_valid_i` = 1 and `dbg_stall_i` = 0:
  - step hit: `single_step`.
  - ebreak hit: `ebreak_en & pipe_ebreak_i`.
  - bp n hit: `BPCTRL[n].enable & (BPADR[n] == pipe_pc_i)`.
  - On any hit, the corresponding HIT bits are set (sticky) and NPC captures `pipe_pc_i`.
- A simultaneous hit set and HIT W1C on the same bit: set wins.
- `dbg_dat_o` holds its last value between acks.

## Timing
- Reset values:
  - All registers 0; `dbg_dat_o`, `npc_o` = 0.
  - `dbg_ack_o`, `dbg_bp_o`, `gpr_req_o`, `gpr_we_o`, `npc_we_o` = 0.
  - `gpr_idx_o`, `gpr_dat_o` = 0; FSM in IDLE.
- Reset mid-transaction aborts it: `gpr_req_o` drops asynchronously and no ack is issued.
- Internal/unmapped access: `dbg_ack_o` is high for exactly the one cycle after the first cycle `dbg_stb_i` is sampled high (latency 1).
- GPR access: `gpr_req_o` rises 1 cycle after the strobe is sampled. `dbg_ack_o` rises on the edge sampling `gpr_ack_i` (minimum latency 2).
- A register write takes effect on the ack edge. `npc_we_o` is high for that same one cycle.
- A hit is visible in HIT and on `dbg_bp_o` one cycle after the retiring cycle. `dbg_bp_o` falls one cycle after the clearing write's ack.

## Test plan
- Reset, write CTRL=0x3, read CTRL -> ack 1 cycle after stb, read data 0x3. Read offset 0x18 -> 0.
- BPADR0=0x1000, BPCTRL0=1, retire PC 0x1000 -> next cycle HIT=0x4, `dbg_bp_o`=1, NPC read=0x1000. Write HIT=0x4 -> `dbg_bp_o`=0.
- `dbg_stall_i`=1, write GPR x5=0xDEAD with `gpr_ack_i` 3 cycles late -> `gpr_req_o` held 3 cycles, `gpr_idx_o`=5, single `dbg_ack_o`. Read back -> 0xDEAD.
- `dbg_stall_i`=0, read GPR x1 -> ack latency 1, data 0, `gpr_req_o` never rises.
- ebreak_en=1, retire ebreak while writing HIT=0x2 on the same edge -> HIT bit1 stays 1.
- Assert `rst` while in GPR state -> `gpr_req_o`=0 immediately, no `dbg_ack_o`, FSM returns to IDLE.

Source files
------------

// File: rtl/riscv_dbg_target.sv
// Per-core debug target: terminates the debug bus, holds control/status/breakpoint
// registers, forwards register-file accesses and flags breakpoint hits on retire.
module riscv_dbg_target #(
  parameter int unsigned XLEN        = 64,
  parameter int unsigned PLEN        = 64,
  parameter int unsigned BREAKPOINTS = 4
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            dbg_stall_i,
  input  logic            dbg_stb_i,
  input  logic            dbg_we_i,
  input  logic [PLEN-1:0] dbg_adr_i,
  input  logic [XLEN-1:0] dbg_dat_i,
  output logic [XLEN-1:0] dbg_dat_o,
  output logic            dbg_ack_o,
  output logic            dbg_bp_o,
  input  logic            pipe_valid_i,
  input  logic [XLEN-1:0] pipe_pc_i,
  input  logic            pipe_ebreak_i,
  output logic            gpr_req_o,
  output logic            gpr_we_o,
  output logic [4:0]      gpr_idx_o,
  output logic [XLEN-1:0] gpr_dat_o,
  input  logic [XLEN-1:0] gpr_dat_i,
  input  logic            gpr_ack_i,
  output logic [XLEN-1:0] npc_o,
  output logic            npc_we_o
);

  localparam int unsigned HitW = 2 + BREAKPOINTS;

  typedef enum logic [1:0] {StIdle, StGpr, StRelease} state_e;

  state_e state_q, state_d;

  logic [1:0]             ctrl_q, ctrl_d;
  logic [HitW-1:0]        hit_q, hit_d, hit_set, hit_clr;
  logic [XLEN-1:0]        npc_q, npc_d;
  logic [XLEN-1:0]        bpadr_q [BREAKPOINTS];
  logic [XLEN-1:0]        bpadr_d [BREAKPOINTS];
  logic [BREAKPOINTS-1:0] bpen_q, bpen_d;
  logic                   ack_q, ack_d;
  logic [XLEN-1:0]        rdat_q, rdat_d;
  logic                   req_q, req_d;
  logic                   gwe_q, gwe_d;
  logic [4:0]             gidx_q, gidx_d;
  logic [XLEN-1:0]        gdat_q, gdat_d;
  logic                   npc_we_q, npc_we_d;
  logic                   npc_wr;
  logic [XLEN-1:0]        int_rdata;

  logic [1:0] region;
  logic [4:0] off;
  logic       unused_adr;

  assign region     = dbg_adr_i[13:12];
  assign off        = dbg_adr_i[7:3];
  assign unused_adr = ^{dbg_adr_i[PLEN-1:14], dbg_adr_i[11:8], dbg_adr_i[2:0]};

  always_comb begin
    hit_set = '0;
    if (pipe_valid_i && !dbg_stall_i) begin
      hit_set[0] = ctrl_q[0];
      hit_set[1] = ctrl_q[1] & pipe_ebreak_i;
      for (int n = 0; n < BREAKPOINTS; n++) begin
        hit_set[2+n] = bpen_q[n] && (bpadr_q[n] == pipe_pc_i);
      end
    end
  end

  always_comb begin
    int_rdata = '0;
    case (off)
      5'd0: int_rdata[1:0] = ctrl_q;
      5'd1: int_rdata[HitW-1:0] = hit_q;
      5'd2: int_rdata = npc_q;
      default: begin
        for (int n = 0; n < BREAKPOINTS; n++) begin
          if (off == 5'(16 + 2 * n)) int_rdata = bpadr_q[n];
          if (off == 5'(17 + 2 * n)) int_rdata[0] = bpen_q[n];
        end
      end
    endcase
  end

  always_comb begin
    state_d  = state_q;
    ctrl_d   = ctrl_q;
    hit_clr  = '0;
    npc_wr   = 1'b0;
    bpadr_d  = bpadr_q;
    bpen_d   = bpen_q;
    ack_d    = 1'b0;
    rdat_d   = rdat_q;
    req_d    = req_q;
    gwe_d    = gwe_q;
    gidx_d   = gidx_q;
    gdat_d   = gdat_q;
    npc_we_d = 1'b0;

    unique case (state_q)
      StIdle: begin
        if (dbg_stb_i) begin
          if (region == 2'd1 && dbg_stall_i) begin
            state_d = StGpr;
            req_d   = 1'b1;
            gwe_d   = dbg_we_i;
            gidx_d  = off;
            gdat_d  = dbg_dat_i;
          end else begin
            state_d = StRelease;
            ack_d   = 1'b1;
            if (!dbg_we_i) begin
              rdat_d = (region == 2'd0) ? int_rdata : '0;
            end else if (region == 2'd0) begin
              case (off)
                5'd0: ctrl_d = dbg_dat_i[1:0];
                5'd1: hit_clr = dbg_dat_i[HitW-1:0];
                5'd2: begin
                  npc_wr   = 1'b1;
                  npc_we_d = 1'b1;
                end
                default: begin
                  for (int n = 0; n < BREAKPOINTS; n++) begin
                    if (off == 5'(16 + 2 * n)) bpadr_d[n] = dbg_dat_i;
                    if (off == 5'(17 + 2 * n)) bpen_d[n] = dbg_dat_i[0];
                  end
                end
              endcase
            end
          end
        end
      end
      StGpr: begin
        if (gpr_ack_i) begin
          state_d = StRelease;
          req_d   = 1'b0;
          gwe_d   = 1'b0;
          ack_d   = 1'b1;
          if (!gwe_q) rdat_d = gpr_dat_i;
        end
      end
      StRelease: begin
        if (!dbg_stb_i) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase

    // A new hit overrides a same-cycle clear of that bit.
    hit_d = (hit_q & ~hit_clr) | hit_set;
    if (npc_wr) begin
      npc_d = dbg_dat_i;
    end else if (|hit_set) begin
      npc_d = pipe_pc_i;
    end else begin
      npc_d = npc_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StIdle;
      ctrl_q   <= '0;
      hit_q    <= '0;
      npc_q    <= '0;
      bpen_q   <= '0;
      ack_q    <= 1'b0;
      rdat_q   <= '0;
      req_q    <= 1'b0;
      gwe_q    <= 1'b0;
      gidx_q   <= '0;
      gdat_q   <= '0;
      npc_we_q <= 1'b0;
      for (int n = 0; n < BREAKPOINTS; n++) bpadr_q[n] <= '0;
    end else begin
      state_q  <= state_d;
      ctrl_q   <= ctrl_d;
      hit_q    <= hit_d;
      npc_q    <= npc_d;
      bpen_q   <= bpen_d;
      ack_q    <= ack_d;
      rdat_q   <= rdat_d;
      req_q    <= req_d;
      gwe_q    <= gwe_d;
      gidx_q   <= gidx_d;
      gdat_q   <= gdat_d;
      npc_we_q <= npc_we_d;
      for (int n = 0; n < BREAKPOINTS; n++) bpadr_q[n] <= bpadr_d[n];
    end
  end

  assign dbg_dat_o = rdat_q;
  assign dbg_ack_o = ack_q;
  assign dbg_bp_o  = |hit_q;
  assign gpr_req_o = req_q;
  assign gpr_we_o  = gwe_q;
  assign gpr_idx_o = gidx_q;
  assign gpr_dat_o = gdat_q;
  assign npc_o     = npc_q;
  assign npc_we_o  = npc_we_q;

endmodule

// File: tb/tb_riscv_dbg_target.sv
// Bench for riscv_dbg_target: table of bus accesses checked through a scoreboard,
// plus hand-written hit, GPR and reset sequences.
module tb_riscv_dbg_target;

  logic        clk = 1'b0;
  logic        rst;
  logic        dbg_stall_i, dbg_stb_i, dbg_we_i;
  logic [63:0] dbg_adr_i, dbg_dat_i, dbg_dat_o;
  logic        dbg_ack_o, dbg_bp_o;
  logic        pipe_valid_i, pipe_ebreak_i;
  logic [63:0] pipe_pc_i;
  logic        gpr_req_o, gpr_we_o;
  logic [4:0]  gpr_idx_o;
  logic [63:0] gpr_dat_o, gpr_dat_i;
  logic        gpr_ack_i;
  logic [63:0] npc_o;
  logic        npc_we_o;

  always #5 clk = ~clk;

  riscv_dbg_target #(.XLEN(64), .PLEN(64), .BREAKPOINTS(4)) dut (
    .clk          (clk),
    .rst          (rst),
    .dbg_stall_i  (dbg_stall_i),
    .dbg_stb_i    (dbg_stb_i),
    .dbg_we_i     (dbg_we_i),
    .dbg_adr_i    (dbg_adr_i),
    .dbg_dat_i    (dbg_dat_i),
    .dbg_dat_o    (dbg_dat_o),
    .dbg_ack_o    (dbg_ack_o),
    .dbg_bp_o     (dbg_bp_o),
    .pipe_valid_i (pipe_valid_i),
    .pipe_pc_i    (pipe_pc_i),
    .pipe_ebreak_i(pipe_ebreak_i),
    .gpr_req_o    (gpr_req_o),
    .gpr_we_o     (gpr_we_o),
    .gpr_idx_o    (gpr_idx_o),
    .gpr_dat_o    (gpr_dat_o),
    .gpr_dat_i    (gpr_dat_i),
    .gpr_ack_i    (gpr_ack_i),
    .npc_o        (npc_o),
    .npc_we_o     (npc_we_o)
  );

  typedef struct {
    logic        is_read;
    logic [63:0] exp;
    string       name;
  } sb_t;

  typedef struct {
    logic        we;
    logic [63:0] adr;
    logic [63:0] dat;
    logic [63:0] exp;
    string       name;
  } vec_t;

  sb_t         sb_q[$];
  vec_t        vecs[21];
  int          checks = 0;
  int          failures = 0;
  int          npc_we_cnt = 0;
  int          gpr_delay = 1;
  int          req_cnt = 0;
  int          req_max = 0;
  bit          req_seen = 0;
  logic [4:0]  last_idx = '0;
  logic [63:0] rf [32];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: every ack must match the oldest pending request.
  always @(negedge clk) begin
    sb_t e;
    if (!rst && dbg_ack_o) begin
      checks++;
      if (sb_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ack: ack with no pending request, data 0x%0h", dbg_dat_o);
      end else begin
        e = sb_q.pop_front();
        if (e.is_read) chk(e.name, dbg_dat_o, e.exp);
      end
    end
    if (npc_we_o) npc_we_cnt++;
  end

  // Register-file model answering gpr_req_o after gpr_delay cycles (0 = never).
  always @(negedge clk) begin
    if (gpr_req_o) begin
      req_seen = 1;
      req_cnt++;
      if (req_cnt > req_max) req_max = req_cnt;
      last_idx = gpr_idx_o;
      if (gpr_delay != 0 && req_cnt == gpr_delay) begin
        gpr_ack_i = 1'b1;
        if (gpr_we_o) rf[gpr_idx_o] = gpr_dat_o;
        else gpr_dat_i = rf[gpr_idx_o];
      end else begin
        gpr_ack_i = 1'b0;
      end
    end else begin
      gpr_ack_i = 1'b0;
      req_cnt   = 0;
    end
  end

  task automatic bus(input logic we, input logic [63:0] adr, input logic [63:0] dat,
                     input logic [63:0] exp, input int exp_lat, input string name);
    int  lat;
    sb_t e;
    lat = 0;
    e.is_read = !we;
    e.exp     = exp;
    e.name    = name;
    sb_q.push_back(e);
    dbg_stb_i = 1'b1;
    dbg_we_i  = we;
    dbg_adr_i = adr;
    dbg_dat_i = dat;
    do begin
      @(negedge clk);
      lat++;
      pipe_valid_i  = 1'b0;
      pipe_ebreak_i = 1'b0;
    end while (!dbg_ack_o && lat < 50);
    chk({name, "_lat"}, 64'(lat), 64'(exp_lat));
    dbg_stb_i = 1'b0;
    dbg_we_i  = 1'b0;
    @(negedge clk);
    chk({name, "_ack_pulse"}, {63'b0, dbg_ack_o}, 64'h0);
  endtask

  task automatic retire(input logic [63:0] pc, input logic ebreak);
    pipe_valid_i  = 1'b1;
    pipe_pc_i     = pc;
    pipe_ebreak_i = ebreak;
    @(negedge clk);
    pipe_valid_i  = 1'b0;
    pipe_ebreak_i = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt0;
    for (int i = 0; i < 32; i++) rf[i] = '0;
    rst = 1'b1;
    dbg_stall_i = 0; dbg_stb_i = 0; dbg_we_i = 0; dbg_adr_i = '0; dbg_dat_i = '0;
    pipe_valid_i = 0; pipe_ebreak_i = 0; pipe_pc_i = '0;
    gpr_dat_i = 64'hBAD0; gpr_ack_i = 0;

    vecs[0]  = '{1'b0, 64'h00,   64'h0,    64'h0,    "rst_ctrl"};
    vecs[1]  = '{1'b0, 64'h08,   64'h0,    64'h0,    "rst_hit"};
    vecs[2]  = '{1'b0, 64'h80,   64'h0,    64'h0,    "rst_bpadr0"};
    vecs[3]  = '{1'b1, 64'h00,   64'h3,    64'h0,    "w_ctrl"};
    vecs[4]  = '{1'b0, 64'h00,   64'h0,    64'h3,    "r_ctrl"};
    vecs[5]  = '{1'b0, 64'h18,   64'h0,    64'h0,    "r_unmapped"};
    vecs[6]  = '{1'b1, 64'h18,   64'hFFFF, 64'h0,    "w_unmapped"};
    vecs[7]  = '{1'b0, 64'h03,   64'h0,    64'h3,    "r_ctrl_lowbits"};
    vecs[8]  = '{1'b1, 64'h90,   64'hABCD, 64'h0,    "w_bpadr1"};
    vecs[9]  = '{1'b0, 64'h90,   64'h0,    64'hABCD, "r_bpadr1"};
    vecs[10] = '{1'b1, 64'h98,   64'hFF,   64'h0,    "w_bpctrl1"};
    vecs[11] = '{1'b0, 64'h98,   64'h0,    64'h1,    "r_bpctrl1"};
    vecs[12] = '{1'b1, 64'hC0,   64'h55,   64'h0,    "w_bpadr4"};
    vecs[13] = '{1'b0, 64'hC0,   64'h0,    64'h0,    "r_bpadr4"};
    vecs[14] = '{1'b1, 64'h3008, 64'h77,   64'h0,    "w_region3"};
    vecs[15] = '{1'b0, 64'h3008, 64'h0,    64'h0,    "r_region3"};
    vecs[16] = '{1'b0, 64'h2000, 64'h0,    64'h0,    "r_region2"};
    vecs[17] = '{1'b1, 64'h00,   64'h0,    64'h0,    "w_ctrl0"};
    vecs[18] = '{1'b1, 64'h80,   64'h1000, 64'h0,    "w_bpadr0"};
    vecs[19] = '{1'b1, 64'h88,   64'h1,    64'h0,    "w_bpctrl0"};
    vecs[20] = '{1'b0, 64'h00,   64'h0,    64'h0,    "r_ctrl0"};

    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("rst_flags", 64'({dbg_ack_o, dbg_bp_o, gpr_req_o, gpr_we_o, npc_we_o}), 64'h0);
    chk("rst_dat", dbg_dat_o, 64'h0);
    chk("rst_npc", npc_o, 64'h0);
    chk("rst_gpr", 64'({gpr_idx_o, gpr_dat_o}), 64'h0);

    for (int i = 0; i < 21; i++) begin
      bus(vecs[i].we, vecs[i].adr, vecs[i].dat, vecs[i].exp, 1, vecs[i].name);
    end

    cnt0 = npc_we_cnt;
    bus(1'b1, 64'h10, 64'h4444, 64'h0, 1, "w_npc");
    chk("npc_we_pulses", 64'(npc_we_cnt - cnt0), 64'h1);
    chk("npc_o", npc_o, 64'h4444);
    bus(1'b0, 64'h10, 64'h0, 64'h4444, 1, "r_npc");

    // Breakpoint 0: miss, stalled match, then real match.
    retire(64'h1008, 1'b0);
    chk("bp_miss", {63'b0, dbg_bp_o}, 64'h0);
    dbg_stall_i = 1'b1;
    retire(64'h1000, 1'b0);
    dbg_stall_i = 1'b0;
    chk("bp_stalled", {63'b0, dbg_bp_o}, 64'h0);
    retire(64'h1000, 1'b0);
    chk("bp_hit", {63'b0, dbg_bp_o}, 64'h1);
    bus(1'b0, 64'h08, 64'h0, 64'h4, 1, "r_hit_bp0");
    bus(1'b0, 64'h10, 64'h0, 64'h1000, 1, "r_npc_bp0");
    bus(1'b1, 64'h08, 64'h4, 64'h0, 1, "w1c_bp0");
    chk("bp_cleared", {63'b0, dbg_bp_o}, 64'h0);

    // Single step.
    bus(1'b1, 64'h00, 64'h1, 64'h0, 1, "w_ctrl_step");
    retire(64'h2000, 1'b0);
    bus(1'b0, 64'h08, 64'h0, 64'h1, 1, "r_hit_step");
    bus(1'b0, 64'h10, 64'h0, 64'h2000, 1, "r_npc_step");
    bus(1'b1, 64'h08, 64'h1, 64'h0, 1, "w1c_step");

    // Ebreak retiring on the same edge as a W1C of its bit.
    bus(1'b1, 64'h00, 64'h2, 64'h0, 1, "w_ctrl_ebreak");
    pipe_valid_i  = 1'b1;
    pipe_pc_i     = 64'h3000;
    pipe_ebreak_i = 1'b1;
    bus(1'b1, 64'h08, 64'h2, 64'h0, 1, "w1c_ebreak_race");
    bus(1'b0, 64'h08, 64'h0, 64'h2, 1, "r_hit_ebreak");
    chk("bp_ebreak", {63'b0, dbg_bp_o}, 64'h1);
    bus(1'b1, 64'h08, 64'h2, 64'h0, 1, "w1c_ebreak");
    bus(1'b0, 64'h08, 64'h0, 64'h0, 1, "r_hit_clear");

    // Stalled GPR write with a slow register file, then readback.
    dbg_stall_i = 1'b1;
    gpr_delay   = 3;
    req_max     = 0;
    bus(1'b1, 64'h1028, 64'hDEAD, 64'h0, 4, "w_gpr5");
    chk("gpr_req_cycles", 64'(req_max), 64'h3);
    chk("gpr_idx", 64'(last_idx), 64'h5);
    chk("gpr_rf5", rf[5], 64'hDEAD);
    gpr_delay = 1;
    bus(1'b0, 64'h1028, 64'h0, 64'hDEAD, 2, "r_gpr5");

    // Unstalled GPR accesses are acked at once and never reach the register file.
    dbg_stall_i = 1'b0;
    req_seen    = 0;
    gpr_dat_i   = 64'hBAD0;
    bus(1'b0, 64'h1008, 64'h0, 64'h0, 1, "r_gpr1_unstalled");
    bus(1'b1, 64'h1028, 64'h1111, 64'h0, 1, "w_gpr5_unstalled");
    chk("gpr_req_unstalled", {63'b0, req_seen}, 64'h0);
    chk("gpr_rf5_kept", rf[5], 64'hDEAD);

    // Reset while waiting in the GPR state.
    dbg_stall_i = 1'b1;
    gpr_delay   = 0;
    dbg_stb_i   = 1'b1;
    dbg_we_i    = 1'b0;
    dbg_adr_i   = 64'h1008;
    @(negedge clk);
    chk("gpr_req_before_rst", {63'b0, gpr_req_o}, 64'h1);
    #2 rst = 1'b1;
    #1;
    chk("gpr_req_async_rst", {63'b0, gpr_req_o}, 64'h0);
    chk("ack_async_rst", {63'b0, dbg_ack_o}, 64'h0);
    dbg_stb_i = 1'b0;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    chk("gpr_req_after_rst", {63'b0, gpr_req_o}, 64'h0);
    bus(1'b0, 64'h00, 64'h0, 64'h0, 1, "r_ctrl_after_rst");
    dbg_stall_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("sb_drained", 64'(sb_q.size()), 64'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
